// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key tracker.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK     = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam int         PS2_FRAME_LEN = 11;

    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_HELD  = 2'd1,
        KEY_BREAK = 2'd2
    } key_state_e;

    // sr holds bits 0..9 of the frame (start in bit 0, parity in bit 9).
    // A frame is good when start is 0, data+parity has odd parity and stop is 1.
    function automatic logic frame_ok(input logic [9:0] sr, input logic stop);
        return (~sr[0]) & (^sr[9:1]) & stop;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the keyboard lines, detects falling
// edges of ps2_clk, assembles 11-bit frames and validates them.
//
// Output handshake: byte_valid is a one-cycle strobe with byte_data stable
// in the same cycle; there is no ready, the consumer must take it then.
// frame_err is a one-cycle strobe for a frame that failed its checks.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    logic            clk_s1_q, clk_s2_q, clk_hist_q;
    logic            dat_s1_q, dat_s2_q;
    logic            fall_q, bit_q;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      byte_data_q, byte_data_d;
    logic            frame_err_q, frame_err_d;

    // Two-flop synchronisers plus a history flop; the detected edge and the
    // data bit sampled with it are registered together so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_hist_q <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            clk_hist_q <= clk_s2_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            fall_q     <= clk_hist_q & ~clk_s2_q;
            bit_q      <= dat_s2_q;
        end
    end

    // Frame assembly, end-of-frame check and mid-frame timeout; an edge in
    // the same cycle as the timeout takes priority.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        if (fall_q) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'(PS2_FRAME_LEN - 1)) begin
                bit_cnt_d = 4'd0;
                shift_d   = '0;
                if (frame_ok(shift_q, bit_q)) begin
                    byte_valid_d = 1'b1;
                    byte_data_d  = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {bit_q, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                bit_cnt_d = 4'd0;
                shift_d   = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Frame state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks the currently held PS/2 key and a running press count, resolving
// typematic repeats, break codes and E0 prefixes ahead of the display path.
// key_state exposes the key FSM state for observation.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] cur_code,
    output logic       key_down,
    output logic [7:0] press_cnt,
    output logic       frame_err,
    output logic [1:0] key_state
);

    logic       byte_valid;
    logic [7:0] byte_data;

    key_state_e state_q, state_d;
    logic       e0_q, e0_d;
    logic [7:0] code_q, code_d;
    logic       down_q, down_d;
    logic [7:0] cnt_q, cnt_d;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    // Key FSM next state. The E0 flag is only remembered and cleared: extended
    // keys deliberately collapse onto their base code.
    always_comb begin
        state_d = state_q;
        e0_d    = e0_q;
        code_d  = code_q;
        down_d  = down_q;
        cnt_d   = cnt_q;
        if (byte_valid) begin
            if (byte_data == PS2_EXT) begin
                e0_d = 1'b1;
            end else begin
                e0_d = 1'b0;
                if (byte_data == PS2_BREAK) begin
                    if (state_q != KEY_BREAK) begin
                        state_d = KEY_BREAK;
                    end
                end else begin
                    case (state_q)
                        KEY_IDLE: begin
                            code_d  = byte_data;
                            down_d  = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                            state_d = KEY_HELD;
                        end
                        KEY_HELD: begin
                            if (byte_data != code_q) begin
                                code_d = byte_data;
                                cnt_d  = cnt_q + 8'd1;
                            end
                        end
                        KEY_BREAK: begin
                            if (byte_data == code_q) begin
                                down_d  = 1'b0;
                                state_d = KEY_IDLE;
                            end else begin
                                state_d = down_q ? KEY_HELD : KEY_IDLE;
                            end
                        end
                        default: state_d = KEY_IDLE;
                    endcase
                end
            end
        end
    end

    // Key FSM and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= KEY_IDLE;
            e0_q    <= 1'b0;
            code_q  <= 8'h00;
            down_q  <= 1'b0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            e0_q    <= e0_d;
            code_q  <= code_d;
            down_q  <= down_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cur_code  = code_q;
    assign key_down  = down_q;
    assign press_cnt = cnt_q;
    assign key_state = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed PS/2 frames, a behavioural
// key model feeding an expected queue, and a monitor that pops on each DUT
// output event (accepted byte or frame_err pulse).
module tb_ps2_key_tracker;
    import ps2_pkg::*;

    localparam int TO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] cur_code;
    logic       key_down;
    logic [7:0] press_cnt;
    logic       frame_err;
    logic [1:0] key_state;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;

    // {frame_err, key_state, key_down, cur_code, press_cnt}
    logic [19:0] exp_q[$];

    logic [1:0] m_st;
    logic       m_kd;
    logic [7:0] m_code;
    logic [7:0] m_cnt;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    ps2_key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .cur_code (cur_code),
        .key_down (key_down),
        .press_cnt(press_cnt),
        .frame_err(frame_err),
        .key_state(key_state)
    );

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural key model
    task automatic model_reset();
        m_st = KEY_IDLE; m_kd = 1'b0; m_code = 8'h00; m_cnt = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) begin
            // prefix only
        end else if (b == 8'hF0) begin
            if (m_st != KEY_BREAK) m_st = KEY_BREAK;
        end else if (m_st == KEY_IDLE) begin
            m_code = b; m_kd = 1'b1; m_cnt = m_cnt + 8'd1; m_st = KEY_HELD;
        end else if (m_st == KEY_HELD) begin
            if (b != m_code) begin
                m_code = b; m_cnt = m_cnt + 8'd1;
            end
        end else begin
            if (b == m_code) begin
                m_kd = 1'b0; m_st = KEY_IDLE;
            end else begin
                m_st = m_kd ? KEY_HELD : KEY_IDLE;
            end
        end
        exp_q.push_back({1'b0, m_st, m_kd, m_code, m_cnt});
    endtask

    task automatic push_err();
        exp_q.push_back({1'b1, m_st, m_kd, m_code, m_cnt});
    endtask

    function automatic logic [10:0] mk(input logic [7:0] b, input logic flip_par, input logic stop);
        return {stop, (~^b) ^ flip_par, b, 1'b0};
    endfunction

    // drivers
    task automatic ps2_bit(input logic b);
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1; ps2_data = b;
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b0;
    endtask

    task automatic send_raw(input logic [10:0] f);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(mk(b, 1'b0, 1'b1));
    endtask

    task automatic do_reset(input string name);
        repeat (8) @(posedge clk);
        chk({name, "_queue_drained"}, 20'(exp_q.size()), 20'd0);
        exp_q.delete();
        #1 rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        @(posedge clk);
        #1;
        chk(name, {frame_err, key_state, key_down, cur_code, press_cnt}, 20'd0);
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
    endtask

    // scoreboard monitor
    task automatic sb_compare(input string name);
        logic [19:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected output %h expected none", name,
                     {frame_err, key_state, key_down, cur_code, press_cnt});
        end else begin
            e = exp_q.pop_front();
            chk(name, {frame_err, key_state, key_down, cur_code, press_cnt}, e);
        end
    endtask

    initial begin
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    sb_compare("sb_byte");
                    pend = 1'b0;
                end
                if (frame_err) begin
                    err_seen++;
                    sb_compare("sb_frame_err");
                end
                if (dut.byte_valid) pend = 1'b1;
            end
        end
    end

    // directed stimulus
    initial begin
        logic [10:0] f;
        int errs_before;
        model_reset();
        do_reset("reset_values");

        // single press with exact latency
        model_byte(8'h1C);
        f = mk(8'h1C, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) ps2_bit(f[i]);
        repeat (4) @(posedge clk);
        #1 chk("latency_not_before_5", 20'(key_down), 20'd0);
        @(posedge clk);
        #1 chk("latency_5_cycles", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h1C, 8'h01}));
        repeat (2) @(posedge clk);
        #1 ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("release", 20'({key_down, cur_code, press_cnt}), 20'({1'b0, 8'h1C, 8'h01}));

        // typematic repeat
        do_reset("reset_typematic");
        repeat (4) send_byte(8'h1C);
        chk("typematic_cnt", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h1C, 8'h01}));
        send_byte(8'h32);
        chk("new_key", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h32, 8'h02}));

        // bad frames
        errs_before = err_seen;
        push_err();
        send_raw(mk(8'h1C, 1'b1, 1'b1));
        push_err();
        send_raw(mk(8'h1C, 1'b0, 1'b0));
        chk("bad_frames_outputs", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h32, 8'h02}));
        chk("bad_frames_err_pulses", 20'(err_seen - errs_before), 20'd2);

        // timeout
        do_reset("reset_timeout");
        errs_before = err_seen;
        f = mk(8'hA5, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        repeat (3) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (TO + 5) @(posedge clk);
        send_byte(8'h32);
        chk("timeout_recover", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h32, 8'h01}));
        chk("timeout_no_err", 20'(err_seen - errs_before), 20'd0);

        // extended key and non-tracked release
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("ext_key", 20'({key_down, cur_code, press_cnt}), 20'({1'b1, 8'h75, 8'h02}));
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("untracked_release", 20'({key_state, key_down, cur_code}), 20'({KEY_HELD, 1'b1, 8'h75}));
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("double_break", 20'({key_state, key_down, cur_code, press_cnt}),
            20'({KEY_IDLE, 1'b0, 8'h75, 8'h02}));

        // wrap after 256 presses
        do_reset("reset_wrap");
        for (int i = 0; i < 256; i++) begin
            send_byte(8'h1C);
            send_byte(8'hF0);
            send_byte(8'h1C);
        end
        chk("wrap", 20'({key_state, key_down, cur_code, press_cnt}), 20'({KEY_IDLE, 1'b0, 8'h1C, 8'h00}));

        // reset mid-frame
        f = mk(8'h5A, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        do_reset("reset_mid_frame");
        send_byte(8'h1C);
        chk("after_mid_reset", 20'({key_state, key_down, cur_code, press_cnt}),
            20'({KEY_HELD, 1'b1, 8'h1C, 8'h01}));

        repeat (10) @(posedge clk);
        chk("queue_empty", 20'(exp_q.size()), 20'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
